// File: rtl/rot_arbiter_if.sv
// Request/response bundle for rot_arbiter: two rotate requesters, one result
// consumer, and the per-client grant counters.
interface rot_arbiter_if #(
    parameter int CNT_W = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [7:0]       req0_din;
    logic [2:0]       req0_s;
    logic             req1_valid;
    logic             req1_ready;
    logic [7:0]       req1_din;
    logic [2:0]       req1_s;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_data;
    logic             rsp_id;
    logic [CNT_W-1:0] gnt_cnt0;
    logic [CNT_W-1:0] gnt_cnt1;

    modport master (
        output req0_valid, req0_din, req0_s,
        output req1_valid, req1_din, req1_s,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_id,
        input  gnt_cnt0, gnt_cnt1
    );

    modport slave (
        input  req0_valid, req0_din, req0_s,
        input  req1_valid, req1_din, req1_s,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_id,
        output gnt_cnt0, gnt_cnt1
    );
endinterface

// File: rtl/rot_arbiter.sv
// Two-client round-robin arbiter sharing one 8-bit right-rotator; the result is
// registered, tagged with the client ID and held until the consumer takes it.
module rot_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    rot_arbiter_if.slave bus
);
    typedef enum logic { IDLE, HOLD } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic [7:0]       data_q, data_d;
    logic             id_q, id_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic       gnt0, gnt1;
    logic [7:0] sel_din;
    logic [2:0] sel_s;
    logic [7:0] rot;

    // On a tie the client that did not win last time gets the grant.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && state_q == IDLE) begin
            gnt0 = bus.req0_valid && (!bus.req1_valid || last_q);
            gnt1 = bus.req1_valid && (!bus.req0_valid || !last_q);
        end
    end

    // Operand mux keyed on the grant, so an unknown operand from the losing
    // client never reaches the rotator.
    always_comb begin
        sel_din = gnt1 ? bus.req1_din : bus.req0_din;
        sel_s   = gnt1 ? bus.req1_s   : bus.req0_s;
        rot     = (sel_din >> sel_s) | (sel_din << (4'd8 - {1'b0, sel_s}));
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        data_d  = data_q;
        id_d    = id_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        if (state_q == IDLE) begin
            if (gnt0 || gnt1) begin
                state_d = HOLD;
                data_d  = rot;
                id_d    = gnt1;
                last_d  = gnt1;
                if (gnt0 && cnt0_q != '1) cnt0_d = cnt0_q + CNT_ONE;
                if (gnt1 && cnt1_q != '1) cnt1_d = cnt1_q + CNT_ONE;
            end
        end else if (bus.rsp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            data_q  <= '0;
            id_q    <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            data_q  <= data_d;
            id_q    <= id_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.rsp_valid  = (state_q == HOLD);
    assign bus.rsp_data   = data_q;
    assign bus.rsp_id     = id_q;
    assign bus.gnt_cnt0   = cnt0_q;
    assign bus.gnt_cnt1   = cnt1_q;
endmodule

// File: doc/rot_arbiter.md
Name: rot_arbiter

Overview:
- Shares one 8-bit right-rotation datapath between two requesters (client 0, client 1).
- Round-robin arbitration on a valid/ready request handshake; one operation in flight at a time.
- Result is registered, tagged with the granted client ID, and held until the consumer accepts it.
- Per-client saturating grant counters for debug and visibility.

Parameters:
- CNT_W, 16, width of each per-client grant counter

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- req0_valid  input  1  client 0 request valid
- req0_ready  output  1  client 0 request accepted this cycle
- req0_din  input  8  client 0 operand
- req0_s  input  3  client 0 right-rotate amount
- req1_valid  input  1  client 1 request valid
- req1_ready  output  1  client 1 request accepted this cycle
- req1_din  input  8  client 1 operand
- req1_s  input  3  client 1 right-rotate amount
- rsp_valid  output  1  result valid
- rsp_ready  input  1  consumer accepts result
- rsp_data  output  8  rotated result
- rsp_id  output  1  client that issued the result
- gnt_cnt0  output  CNT_W  saturating count of client 0 grants
- gnt_cnt1  output  CNT_W  saturating count of client 1 grants

Behaviour:
- One clock and one reset: clk, synchronous active-high rst. No other resets and no asynchronous paths.
- Rotation function: result = {din[s-1:0], din[7:s]}. s=0 passes din through unchanged. s=7 gives {din[6:0], din[7]}.
- Rotator is internal combinational logic; only its registered output is visible.
- FSM states:
  - IDLE: no result held; rsp_valid=0.
  - HOLD: result held; rsp_valid=1.
- IDLE behaviour:
  - If any reqN_valid=1, grant one client per the arbitration rules, assert its reqN_ready combinationally in that cycle, and register the rotated result, rsp_id and the counter update. Next state is HOLD.
  - If no request is valid, stay in IDLE.
- HOLD behaviour:
  - rsp_data and rsp_id stay stable while rsp_valid=1 and rsp_ready=0.
  - When rsp_ready=1, go to IDLE next cycle.
  - No same-cycle re-grant in HOLD; both reqN_ready=0 for the whole of HOLD.
  - Throughput: at most one operation per 2 cycles.
- Latency: request accepted in cycle N, rsp_valid=1 in cycle N+1.
- Arbitration:
  - Round-robin pointer `last`, reset value 1, so client 0 wins the first tie.
  - Only one valid: that client wins.
  - Both valid: the client not equal to `last` wins.
  - `last` updates to the winner only on a grant.
- readys:
  - reqN_ready is high only in IDLE and only for the winner; never both high.
  - reqN_ready does not depend on rsp_ready.
- Requester rule: a requester must hold valid, din and s stable until ready. The block does not check this. A valid that drops before grant is simply not served.
- Counters:
  - gnt_cntN increments by 1 on each grant to client N.
  - At 2^CNT_W-1 the counter saturates and holds; it does not wrap.
- Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, req0_ready=0, req1_ready=0, gnt_cnt0=0, gnt_cnt1=0, state=IDLE, last=1.
- Reset mid-operation: rst in HOLD discards the held result; next cycle all outputs are at reset values. Requests valid during rst are not granted.
- rsp_ready while in IDLE is ignored.
- X on reqN_s or reqN_din for a non-granted client must not propagate to outputs.

Test Plan:
- Single request: reset, then req0 din=8'hB4, s=3 held valid → req0_ready=1 for one cycle; next cycle rsp_valid=1, rsp_data=8'h96, rsp_id=0, gnt_cnt0=1.
- Rotation sweep: din=8'h81, s=0..7 on client 1 with rsp_ready=1 → rsp_data = 81,C0,60,30,18,0C,06,03; rsp_id=1 for all; gnt_cnt1=8.
- Fairness: both clients valid continuously, rsp_ready=1 → grants alternate 0,1,0,1 (first grant to 0); req ready pulses every 2 cycles; after 10 grants gnt_cnt0=gnt_cnt1=5.
- Backpressure: rsp_ready=0 for 5 cycles after a result → rsp_data/rsp_id stable; reqN_ready=0 throughout; grant resumes the cycle after rsp_ready=1 is seen.
- Reset mid-hold: assert rst in HOLD with rsp_ready=0 → next cycle rsp_valid=0, rsp_data=0, both counters 0; the first grant after reset goes to client 0 when both are valid.
- Saturation: CNT_W=2, six grants to client 0 → gnt_cnt0 reads 1,2,3,3,3,3.
